// File: rtl/pc_sequencer.sv
// Program counter owner and instruction fetch sequencer: FETCH waits on imem_ready,
// EXEC presents the instruction to decode and selects the next PC, HALT parks the core.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned WAIT_LIMIT   = 15
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    input  logic        imem_ready,
    output logic        instr_valid,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_imm,
    input  logic        jump,
    input  logic [25:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_addr,
    input  logic        halt,
    output logic        halted,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    localparam logic [7:0] WAIT_LIMIT_C = 8'(WAIT_LIMIT);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        fetch_fault_q, fetch_fault_d;
    logic [31:0] branch_off;
    logic        unused_jr_low;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_off    = {{14{branch_imm[15]}}, branch_imm, 2'b00};
    assign unused_jr_low = ^jr_addr[1:0];

    // Fetch handshake: imem_req stays high for the whole FETCH phase; the transfer
    // for address pc completes on the first rising edge where imem_req && imem_ready.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        wait_cnt_d    = wait_cnt_q;
        fetch_fault_d = fetch_fault_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    state_d    = S_EXEC;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == WAIT_LIMIT_C) begin
                    state_d       = S_HALT;
                    fetch_fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_EXEC: begin
                if (halt) begin
                    state_d = S_HALT;
                end else if (!stall) begin
                    state_d = S_FETCH;
                    if (jr) begin
                        pc_d = {jr_addr[31:2], 2'b00};
                    end else if (jump) begin
                        pc_d = {pc_plus4[31:28], jump_target, 2'b00};
                    end else if (branch_taken) begin
                        pc_d = pc_plus4 + branch_off;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_VECTOR;
            wait_cnt_q    <= 8'd0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            wait_cnt_q    <= wait_cnt_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    assign pc          = pc_q;
    assign imem_req    = (state_q == S_FETCH) & ~reset;
    assign instr_valid = (state_q == S_EXEC) & ~reset;
    assign halted      = (state_q == S_HALT);
    assign fetch_fault = fetch_fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed redirect/stall/halt/fault vectors, with a scoreboard
// of expected PCs popped by a monitor on every EXEC cycle.
module tb_pc_sequencer;

    localparam int WL = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        imem_req;
    logic        imem_ready = 1'b0;
    logic        instr_valid;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_imm;
    logic        jump;
    logic [25:0] jump_target;
    logic        jr;
    logic [31:0] jr_addr;
    logic        halt;
    logic        halted;
    logic        fetch_fault;

    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          mem_wait = 0;
    int          req_run  = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_VECTOR(32'h0000_0000), .WAIT_LIMIT(WL)) dut (
        .clk(clk), .reset(reset), .pc(pc), .pc_plus4(pc_plus4),
        .imem_req(imem_req), .imem_ready(imem_ready), .instr_valid(instr_valid),
        .stall(stall), .branch_taken(branch_taken), .branch_imm(branch_imm),
        .jump(jump), .jump_target(jump_target), .jr(jr), .jr_addr(jr_addr),
        .halt(halt), .halted(halted), .fetch_fault(fetch_fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: ready after mem_wait low cycles of a request; mem_wait < 0 means never.
    always @(negedge clk) begin
        if (imem_req === 1'b1) begin
            imem_ready = (mem_wait >= 0) && (req_run >= mem_wait);
            req_run++;
        end else begin
            imem_ready = 1'b0;
            req_run    = 0;
        end
    end

    always @(negedge clk) begin
        if (instr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL exec_unexpected: got pc %h expected no EXEC", pc);
            end else begin
                check("exec_pc", pc, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctl();
        stall = 0; branch_taken = 0; branch_imm = '0; jump = 0;
        jump_target = '0; jr = 0; jr_addr = '0; halt = 0;
    endtask

    task automatic wait_exec(output int waited);
        waited = 0;
        while (instr_valid !== 1'b1 && waited < 200) begin
            step();
            waited++;
        end
        if (instr_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_exec_timeout: got instr_valid %b expected 1", instr_valid);
        end
    endtask

    task automatic leave_exec();
        int w;
        wait_exec(w);
        step();
        clear_ctl();
    endtask

    task automatic exec_and_go(input logic [31:0] next_pc);
        int w;
        wait_exec(w);
        exp_q.push_back(next_pc);
        step();
        clear_ctl();
    endtask

    task automatic count_fetch(output int n);
        n = 0;
        while (imem_req === 1'b1 && n < 300) begin
            n++;
            step();
        end
    endtask

    initial begin
        int w;
        int n;
        clear_ctl();
        reset = 1;
        step();
        step();
        check("reset_pc", pc, 32'h0);
        check("reset_imem_req", imem_req, 0);
        check("reset_instr_valid", instr_valid, 0);
        check("reset_halted", halted, 0);
        check("reset_fault", fetch_fault, 0);
        exp_q.push_back(32'h0);
        reset = 0;

        // Sequential flow with zero-wait memory
        exec_and_go(32'h4);
        check("exec_gap", instr_valid, 0);
        wait_exec(w);
        check("zero_wait_latency", w, 1);
        exec_and_go(32'h8);

        // Jump to 0x100, then branches
        jump = 1; jump_target = 26'h40;
        exec_and_go(32'h100);
        branch_taken = 1; branch_imm = 16'hFFFF;
        exec_and_go(32'h100);
        branch_taken = 1; branch_imm = 16'h0003;
        exec_and_go(32'h110);

        // jr / jump / priorities
        jr = 1; jr_addr = 32'h1000_0041;
        exec_and_go(32'h1000_0040);
        jump = 1; jump_target = 26'h0000010;
        exec_and_go(32'h1000_0040);
        jr = 1; jump = 1; jr_addr = 32'h203; jump_target = 26'h3FFFFFF;
        exec_and_go(32'h200);
        jump = 1; jump_target = 26'h0; branch_taken = 1; branch_imm = 16'h0005;
        exec_and_go(32'h0);

        // Wrap at top of address space
        jr = 1; jr_addr = 32'hFFFF_FFFF;
        exec_and_go(32'hFFFF_FFFC);
        exec_and_go(32'h0);

        // Wait states: 3 low cycles, then ready exactly in the limit cycle
        wait_exec(w);
        mem_wait = 3;
        exec_and_go(32'h4);
        count_fetch(n);
        check("wait3_req_cycles", n, 4);
        wait_exec(w);
        mem_wait = WL;
        exec_and_go(32'h8);
        count_fetch(n);
        check("limit_req_cycles", n, WL + 1);
        check("limit_no_fault", fetch_fault, 0);
        mem_wait = 0;

        // Stall for three EXEC cycles at pc 8
        stall = 1;
        wait_exec(w);
        exp_q.push_back(32'h8);
        step();
        exp_q.push_back(32'h8);
        step();
        exp_q.push_back(32'h8);
        step();
        check("stall_valid", instr_valid, 1);
        check("stall_pc", pc, 32'h8);
        stall = 0;
        exec_and_go(32'hC);

        // Halt together with stall, then ignore redirects while halted
        stall = 1; halt = 1;
        leave_exec();
        check("halt_halted", halted, 1);
        check("halt_no_valid", instr_valid, 0);
        check("halt_no_req", imem_req, 0);
        jr = 1; jr_addr = 32'h400;
        for (int i = 0; i < 10; i++) begin
            step();
            check("halt_pc_frozen", pc, 32'hC);
        end
        clear_ctl();

        // Reset out of HALT
        reset = 1;
        step();
        check("rst_halt_pc", pc, 32'h0);
        check("rst_halt_halted", halted, 0);
        check("rst_halt_req", imem_req, 0);
        exp_q.push_back(32'h0);
        reset = 0;
        #1;
        check("rst_halt_req_resume", imem_req, 1);

        // Fetch timeout
        wait_exec(w);
        mem_wait = -1;
        leave_exec();
        count_fetch(n);
        check("fault_req_cycles", n, WL + 1);
        check("fault_flag", fetch_fault, 1);
        check("fault_halted", halted, 1);
        check("fault_pc", pc, 32'h4);

        reset = 1;
        step();
        check("rst_fault_clear", fetch_fault, 0);
        check("rst_fault_halted", halted, 0);
        mem_wait = 0;
        exp_q.push_back(32'h0);
        reset = 0;

        // Reset mid-FETCH at pc 8
        exec_and_go(32'h4);
        wait_exec(w);
        mem_wait = 5;
        leave_exec();
        step();
        step();
        check("midfetch_pc", pc, 32'h8);
        check("midfetch_req", imem_req, 1);
        reset = 1;
        step();
        check("rst_fetch_pc", pc, 32'h0);
        check("rst_fetch_req", imem_req, 0);
        check("rst_fetch_valid", instr_valid, 0);
        reset = 0;
        mem_wait = 0;
        exp_q.push_back(32'h0);
        #1;
        check("rst_fetch_req_resume", imem_req, 1);
        wait_exec(w);
        step();
        step();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
